// File: rtl/mem_load_sequencer.sv
// Load sequencer for the input (feature-map) and kernel memories: takes address/data
// pairs from the a/b host streams, filters them per region and raises data_ready when both regions are full.
module mem_load_sequencer #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int INPUT_WORDS   = 32768,
    parameter int KERNEL_WORDS  = 512
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     load_start,
    input  logic [IO_DATA_WIDTH-1:0] a_input,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [IO_DATA_WIDTH-1:0] b_input,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic                     int_mem_we,
    output logic [IO_DATA_WIDTH-1:0] int_mem_addr,
    output logic [IO_DATA_WIDTH-1:0] int_mem_din,
    output logic                     data_ready,
    input  logic                     compute_done,
    output logic                     busy,
    output logic                     load_err
);

    localparam int MAX_WORDS = (INPUT_WORDS > KERNEL_WORDS) ? INPUT_WORDS : KERNEL_WORDS;
    localparam int CNT_W     = (MAX_WORDS > 0) ? $clog2(MAX_WORDS + 1) : 1;

    localparam logic [CNT_W-1:0] INPUT_EXP    = CNT_W'(INPUT_WORDS);
    localparam logic [CNT_W-1:0] KERNEL_EXP   = CNT_W'(KERNEL_WORDS);
    localparam logic [31:0]      INPUT_DEPTH  = INPUT_WORDS;
    localparam logic [31:0]      KERNEL_DEPTH = KERNEL_WORDS;
    localparam logic             NOTHING_TO_LOAD = (INPUT_WORDS == 0) && (KERNEL_WORDS == 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_READY = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_in_q, cnt_in_d;
    logic [CNT_W-1:0]       cnt_k_q, cnt_k_d;
    logic                   we_q, we_d;
    logic [IO_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [IO_DATA_WIDTH-1:0] din_q, din_d;
    logic                   err_q, err_d;

    logic        region;
    logic [14:0] word_addr;
    logic        in_range;
    logic        has_room;
    logic        xfer;

    assign region    = a_input[15];
    assign word_addr = a_input[14:0];
    assign in_range  = region ? ({17'd0, word_addr} < KERNEL_DEPTH)
                              : ({17'd0, word_addr} < INPUT_DEPTH);
    assign has_room  = region ? (cnt_k_q < KERNEL_EXP) : (cnt_in_q < INPUT_EXP);
    // Both readies are high only in LOAD, so a handshake is just both valids there.
    assign xfer      = (state_q == S_LOAD) && a_valid && b_valid;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_in_d = cnt_in_q;
        cnt_k_d  = cnt_k_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    cnt_in_d = '0;
                    cnt_k_d  = '0;
                    err_d    = 1'b0;
                    state_d  = NOTHING_TO_LOAD ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (in_range && has_room) begin
                        we_d   = 1'b1;
                        addr_d = a_input;
                        din_d  = b_input;
                        if (region) cnt_k_d  = cnt_k_q + CNT_W'(1);
                        else        cnt_in_d = cnt_in_q + CNT_W'(1);
                        if ((cnt_in_d == INPUT_EXP) && (cnt_k_d == KERNEL_EXP)) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // One extra cycle lets the final write strobe land before data_ready rises.
            S_FLUSH: state_d = S_READY;
            S_READY: begin
                if (compute_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; addr/din are reset too so outputs are 0 after reset.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= S_IDLE;
            cnt_in_q <= '0;
            cnt_k_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_in_q <= cnt_in_d;
            cnt_k_q  <= cnt_k_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            err_q    <= err_d;
        end
    end

    assign a_ready      = (state_q == S_LOAD);
    assign b_ready      = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign data_ready   = (state_q == S_READY);
    assign int_mem_we   = we_q;
    assign int_mem_addr = addr_q;
    assign int_mem_din  = din_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Self-checking bench for mem_load_sequencer: directed scenarios plus randomized loads,
// with every cycle compared against a flag/count based reference model.
module tb_mem_load_sequencer;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b0;
    logic          load_start = 1'b0;
    logic [DW-1:0] a_input = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] b_input = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic          int_mem_we;
    logic [DW-1:0] int_mem_addr;
    logic [DW-1:0] int_mem_din;
    logic          data_ready;
    logic          compute_done = 1'b0;
    logic          busy;
    logic          load_err;

    mem_load_sequencer #(
        .IO_DATA_WIDTH(DW),
        .INPUT_WORDS  (IW),
        .KERNEL_WORDS (KW)
    ) dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .load_start  (load_start),
        .a_input     (a_input),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b_input     (b_input),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .int_mem_we  (int_mem_we),
        .int_mem_addr(int_mem_addr),
        .int_mem_din (int_mem_din),
        .data_ready  (data_ready),
        .compute_done(compute_done),
        .busy        (busy),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int we_pulses = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a load is "loading" until both region counts reach their
    // expected totals, then one flush cycle, then data is held until compute_done.
    typedef struct {
        bit          loading;
        bit          flushing;
        bit          held;
        bit          err;
        bit          we;
        logic [15:0] addr;
        logic [15:0] din;
        int          cnt_in;
        int          cnt_k;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t z;
        z.loading = 0; z.flushing = 0; z.held = 0; z.err = 0; z.we = 0;
        z.addr = '0; z.din = '0; z.cnt_in = 0; z.cnt_k = 0;
        return z;
    endfunction

    function automatic model_t model_next(model_t s, logic ls, logic cd, logic av, logic bv,
                                          logic [15:0] a, logic [15:0] b);
        model_t n = s;
        int     wa;
        int     limit;
        int     cnt;
        n.we = 0;
        if (s.flushing) begin
            n.flushing = 0;
            n.held     = 1;
        end else if (s.held) begin
            if (cd) n.held = 0;
        end else if (s.loading) begin
            if (av && bv) begin
                wa    = int'(a[14:0]);
                limit = a[15] ? KW : IW;
                cnt   = a[15] ? s.cnt_k : s.cnt_in;
                if (wa < limit && cnt < limit) begin
                    if (a[15]) n.cnt_k = s.cnt_k + 1;
                    else       n.cnt_in = s.cnt_in + 1;
                    n.we   = 1;
                    n.addr = a;
                    n.din  = b;
                    if (n.cnt_in == IW && n.cnt_k == KW) begin
                        n.loading  = 0;
                        n.flushing = 1;
                    end
                end else begin
                    n.err = 1;
                end
            end
        end else if (ls) begin
            n.cnt_in = 0;
            n.cnt_k  = 0;
            n.err    = 0;
            if (IW == 0 && KW == 0) n.flushing = 1;
            else                    n.loading  = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) m <= model_reset();
        else            m <= model_next(m, load_start, compute_done, a_valid, b_valid, a_input, b_input);
    end

    always @(negedge clk) begin
        check("a_ready",      a_ready,      m.loading);
        check("b_ready",      b_ready,      m.loading);
        check("busy",         busy,         m.loading | m.flushing);
        check("data_ready",   data_ready,   m.held);
        check("int_mem_we",   int_mem_we,   m.we);
        check("load_err",     load_err,     m.err);
        check("int_mem_addr", int_mem_addr, m.addr);
        check("int_mem_din",  int_mem_din,  m.din);
        if (int_mem_we) we_pulses <= we_pulses + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [15:0] a, input logic [15:0] b);
        a_input = a;
        b_input = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic pulse_done();
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int cyc;
        logic [15:0] in_addr [6];
        in_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h8001};

        repeat (3) step();
        check("rst_we",    int_mem_we,   0);
        check("rst_addr",  int_mem_addr, 0);
        check("rst_ready", data_ready,   0);
        arst_n_in = 1'b1;
        step();
        check("idle_a_ready", a_ready, 0);

        // Full load with continuous valids.
        pulse_start();
        check("load_busy", busy, 1);
        p0 = we_pulses;
        for (int i = 0; i < 6; i++) xfer(in_addr[i], 16'(16'h10 + i));
        check("last_we",    int_mem_we,   1);
        check("last_addr",  int_mem_addr, 16'h8001);
        check("last_din",   int_mem_din,  16'h0015);
        check("flush_busy", busy,         1);
        check("flush_nrdy", data_ready,   0);
        step();
        check("t2_ready",   data_ready,   1);
        check("t2_busy",    busy,         0);
        check("six_pulses", we_pulses - p0, 6);
        check("clean_err",  load_err,     0);

        // load_start ignored in READY; compute_done releases.
        pulse_start();
        check("ready_hold", data_ready, 1);
        pulse_done();
        check("ready_drop", data_ready, 0);
        check("idle_busy",  busy,       0);

        // Stall: only a_valid for three cycles.
        pulse_start();
        p0 = we_pulses;
        a_input = 16'h0000;
        a_valid = 1'b1;
        b_valid = 1'b0;
        repeat (3) step();
        check("stall_none", we_pulses - p0, 0);
        b_input = 16'h00AA;
        b_valid = 1'b1;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("stall_we",   int_mem_we,  1);
        check("stall_din",  int_mem_din, 16'h00AA);
        step();
        step();
        check("stall_once", we_pulses - p0, 1);

        // Out-of-range and over-count writes are consumed but dropped.
        xfer(16'h0007, 16'h0077);
        check("oor_no_we",  int_mem_we, 0);
        check("oor_err",    load_err,   1);
        xfer(16'h8000, 16'h0020);
        xfer(16'h8001, 16'h0021);
        xfer(16'h8000, 16'h0022);
        check("full_no_we", int_mem_we, 0);
        xfer(16'h0001, 16'h0031);
        xfer(16'h0002, 16'h0032);
        xfer(16'h0003, 16'h0033);
        step();
        check("err_ready",  data_ready, 1);
        check("err_sticky", load_err,   1);
        pulse_done();
        pulse_start();
        check("err_clear",  load_err,   0);

        // Asynchronous reset after two writes.
        xfer(16'h0000, 16'h0040);
        xfer(16'h0001, 16'h0041);
        arst_n_in = 1'b0;
        #1;
        check("arst_we",    int_mem_we,   0);
        check("arst_addr",  int_mem_addr, 0);
        check("arst_din",   int_mem_din,  0);
        check("arst_busy",  busy,         0);
        check("arst_ready", a_ready,      0);
        step();
        arst_n_in = 1'b1;
        step();
        step();
        check("post_rst_a_ready", a_ready,    0);
        check("post_rst_ready",   data_ready, 0);

        // compute_done and load_start together in READY.
        pulse_start();
        for (int i = 0; i < 6; i++) xfer(in_addr[i], 16'(16'h50 + i));
        step();
        check("tie_ready", data_ready, 1);
        compute_done = 1'b1;
        load_start   = 1'b1;
        step();
        compute_done = 1'b0;
        load_start   = 1'b0;
        check("tie_busy",    busy,       0);
        check("tie_a_ready", a_ready,    0);
        check("tie_drop",    data_ready, 0);
        step();
        check("tie_idle", busy, 0);

        // Randomized loads.
        for (int ld = 0; ld < 30; ld++) begin
            pulse_start();
            cyc = 0;
            while (!data_ready && cyc < 500) begin
                a_valid      = ($urandom_range(3) != 0);
                b_valid      = ($urandom_range(3) != 0);
                load_start   = ($urandom_range(9) == 0);
                compute_done = ($urandom_range(9) == 0);
                b_input      = 16'($urandom);
                if ($urandom_range(7) == 0) a_input = 16'($urandom);
                else a_input = {1'($urandom_range(1)), 12'd0, 3'($urandom_range(7))};
                step();
                cyc++;
            end
            a_valid = 1'b0;
            b_valid = 1'b0;
            load_start = 1'b0;
            compute_done = 1'b0;
            check("rand_ready", data_ready, 1);
            for (int k = 0; k < int'($urandom_range(3)); k++) begin
                load_start = ($urandom_range(1) == 0);
                step();
            end
            load_start = 1'b0;
            pulse_done();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_load_sequencer.md
Name: mem_load_sequencer

Overview:
- Sequences the loading of the on-chip input (feature-map) and kernel memories from the a/b host streams before each compute pass.
- Stream a carries the address; bit 15 selects kernel (1) or input (0) memory. Stream b carries the data word.
- Counts the writes to each region, drops writes that are out of range or past the expected count, and raises data_ready once both regions are complete. data_ready is held until the controller reports that compute has finished.
- Sits between the host I/O pins and the memory write ports / controller data_ready input.

Parameters:
- IO_DATA_WIDTH, 16, width of a_input/b_input and the memory data word.
- INPUT_WORDS, 32768, number of input-memory writes expected per load (input memory depth).
- KERNEL_WORDS, 512, number of kernel-memory writes expected per load (kernel memory depth).

Ports:
- clk  in  1  single system clock, rising edge.
- arst_n_in  in  1  reset; asynchronous assertion, active low.
- load_start  in  1  single-cycle request to begin a new load.
- a_input  in  IO_DATA_WIDTH  write address; bit 15 = region select, low bits = word address.
- a_valid  in  1  a_input valid.
- a_ready  out  1  sequencer can accept a.
- b_input  in  IO_DATA_WIDTH  write data.
- b_valid  in  1  b_input valid.
- b_ready  out  1  sequencer can accept b.
- int_mem_we  out  1  registered write strobe to the memories.
- int_mem_addr  out  IO_DATA_WIDTH  registered address (bit 15 kept as the region select).
- int_mem_din  out  IO_DATA_WIDTH  registered data.
- data_ready  out  1  both memories loaded; held high until compute_done.
- compute_done  in  1  single-cycle pulse from the controller: compute pass consumed the data.
- busy  out  1  high in LOAD or FLUSH.
- load_err  out  1  sticky: at least one transfer was dropped in the current load.

Behaviour:
- Reset: state=IDLE, both counters=0, all outputs 0 (int_mem_addr and int_mem_din = 0).
- Reset mid-load aborts immediately; no partial data_ready is produced.
- States: IDLE, LOAD, FLUSH, READY.
- IDLE:
  - a_ready=b_ready=0.
  - load_start -> LOAD; clears both counters and load_err in the same edge.
- LOAD:
  - a_ready=b_ready=1. Ready depends on state only, never on valid or data.
  - Transfer fires on a cycle T where a_valid & b_valid (both readies are high). If only one valid is high, nothing is consumed from either stream.
  - On a transfer, the region is r = a_input[15]; the word address is a_input[14:0].
  - The transfer is accepted when both hold: word address < depth of region r (INPUT_WORDS or KERNEL_WORDS), and the count of region r < its expected count.
  - Accepted transfer: at T+1, int_mem_we=1, int_mem_addr=a_input, int_mem_din=b_input; the region r counter increments.
  - Rejected transfer: it is consumed (handshake completes) but int_mem_we stays 0 at T+1, load_err sets at T+1, and the counter is unchanged.
  - int_mem_we is high for exactly one cycle per accepted transfer, so back-to-back transfers give a continuous strobe.
  - Repeated addresses are written and counted; uniqueness is not checked.
- LOAD -> FLUSH: on the edge where the final accepted transfer makes both counters equal to their expected counts. At T+1 the state is FLUSH and the final write strobe is on int_mem_we.
- FLUSH:
  - a_ready=b_ready=0.
  - Unconditionally -> READY on the next edge.
  - data_ready goes high at T+2, after the last memory write has landed.
- READY:
  - data_ready=1, a_ready=b_ready=0.
  - compute_done -> IDLE; data_ready low the following cycle.
- busy = (state==LOAD)|(state==FLUSH), registered-state decode.
- Ignored inputs:
  - load_start outside IDLE.
  - compute_done outside READY.
  - load_start and compute_done in the same READY cycle: compute_done wins -> IDLE; load_start is dropped.
- Counter width: $clog2(max(INPUT_WORDS,KERNEL_WORDS)+1) bits, saturating at the expected count.
- Degenerate parameters: if both expected counts are 0, load_start goes IDLE->FLUSH directly.
- load_err holds until the next load_start in IDLE or reset; it is visible in READY.

Test Plan (INPUT_WORDS=4, KERNEL_WORDS=2):
- Reset, then load_start; stream input addrs 0..3 and kernel addrs 0x8000,0x8001 with data 0x10..0x15, both valids high every cycle -> six consecutive int_mem_we pulses with matching addr/din one cycle after each handshake; FLUSH then data_ready high 2 cycles after the last handshake; load_err=0.
- a_valid=1 with b_valid=0 for 3 cycles, then b_valid=1 -> no strobe during the stall; exactly one write of the held pair, no duplicate.
- During LOAD send addr 0x0007 (input, out of range) and a 3rd kernel write 0x8000 after the kernel region is full -> both consumed, no int_mem_we, load_err=1; data_ready still arrives after the remaining valid writes.
- In READY pulse load_start -> ignored, data_ready stays 1; pulse compute_done -> IDLE, data_ready 0 next cycle; second load_start clears load_err and restarts counters at 0.
- Assert arst_n_in low after 2 of 6 writes -> all outputs 0 asynchronously; after release, state IDLE and a_ready=0 until load_start.
- Same cycle in READY: compute_done=1 and load_start=1 -> IDLE, counters not cleared, busy stays 0.
